// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types and constants for the memory initiator.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

   localparam int MEM_WORD_W        = 32;
   localparam int MEM_DEPTH_DEFAULT = 256;
   localparam int MEM_CNT_W         = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lat_counter.sv
`default_nettype none
// ============================================================================
// Module   : mem_lat_counter
// Brief    : Loadable down-counter with zero flag; times the memory access.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lat_counter
   import mem_pkg::*;
#(
   parameter int WIDTH = MEM_CNT_W
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : mem_initiator
// Brief    : Converts datapath load/store requests into timed word accesses
//            on a simple memory port. Define MEM_ALIGN_CHECK_EN to reject
//            misaligned byte addresses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_initiator
   import mem_pkg::*;
#(
   parameter int MEM_LAT = 1,
   parameter int DEPTH   = MEM_DEPTH_DEFAULT
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_we,
   input  logic [31:0]           req_addr,
   input  logic [MEM_WORD_W-1:0] req_wdata,
   output logic                  req_ready,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [MEM_WORD_W-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_ewr,
   output logic [31:0]           mem_dir,
   output logic [MEM_WORD_W-1:0] mem_din,
   input  logic [MEM_WORD_W-1:0] mem_dout
);

   localparam logic [MEM_CNT_W-1:0] c_lat_init = MEM_CNT_W'(MEM_LAT - 1);
   localparam logic [31:0]          c_depth    = 32'(DEPTH);

   mem_state_t            r_state,      w_state_nxt;
   logic                  r_req_ready,  w_req_ready_nxt;
   logic                  r_resp_valid, w_resp_valid_nxt;
   logic [MEM_WORD_W-1:0] r_resp_rdata, w_resp_rdata_nxt;
   logic                  r_resp_err,   w_resp_err_nxt;
   logic                  r_mem_ewr,    w_mem_ewr_nxt;
   logic [31:0]           r_mem_dir,    w_mem_dir_nxt;
   logic [MEM_WORD_W-1:0] r_mem_din,    w_mem_din_nxt;

   logic [31:0] w_index;
   logic        w_misaligned;
   logic        w_reject;
   logic        w_cnt_load;
   logic        w_cnt_dec;
   logic        w_cnt_zero;

   assign w_index = {2'b00, req_addr[31:2]};

`ifdef MEM_ALIGN_CHECK_EN
   assign w_misaligned = (req_addr[1:0] != 2'b00);
`else
   // Byte offset is ignored; the reference only keeps the whole address port in use.
   assign w_misaligned = 1'b0 & (|req_addr[1:0]);
`endif

   assign w_reject = (w_index >= c_depth) || w_misaligned;

   mem_lat_counter #(
      .WIDTH (MEM_CNT_W)
   ) u_lat_counter (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_cnt_load),
      .i_load_val (c_lat_init),
      .i_dec      (w_cnt_dec),
      .o_zero     (w_cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
         r_mem_ewr    <= 1'b0;
         r_mem_dir    <= '0;
         r_mem_din    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_req_ready  <= w_req_ready_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_resp_rdata <= w_resp_rdata_nxt;
         r_resp_err   <= w_resp_err_nxt;
         r_mem_ewr    <= w_mem_ewr_nxt;
         r_mem_dir    <= w_mem_dir_nxt;
         r_mem_din    <= w_mem_din_nxt;
      end
   end

   // Every output is computed one cycle ahead so it leaves the block from a flop.
   always_comb begin
      w_state_nxt      = r_state;
      w_req_ready_nxt  = r_req_ready;
      w_resp_valid_nxt = r_resp_valid;
      w_resp_rdata_nxt = r_resp_rdata;
      w_resp_err_nxt   = r_resp_err;
      w_mem_ewr_nxt    = r_mem_ewr;
      w_mem_dir_nxt    = r_mem_dir;
      w_mem_din_nxt    = r_mem_din;
      w_cnt_load       = 1'b0;
      w_cnt_dec        = 1'b0;

      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_req_ready_nxt = 1'b0;
               if (w_reject) begin
                  w_state_nxt      = RESP;
                  w_resp_valid_nxt = 1'b1;
                  w_resp_err_nxt   = 1'b1;
                  w_resp_rdata_nxt = '0;
               end else begin
                  w_state_nxt   = ACCESS;
                  w_mem_ewr_nxt = req_we;
                  w_mem_dir_nxt = w_index;
                  w_mem_din_nxt = req_wdata;
                  w_cnt_load    = 1'b1;
               end
            end
         end

         ACCESS: begin
            if (w_cnt_zero) begin
               w_state_nxt      = RESP;
               w_mem_ewr_nxt    = 1'b0;
               w_resp_valid_nxt = 1'b1;
               w_resp_err_nxt   = 1'b0;
               w_resp_rdata_nxt = r_mem_ewr ? '0 : mem_dout;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end

         RESP: begin
            if (resp_ready) begin
               w_state_nxt      = IDLE;
               w_resp_valid_nxt = 1'b0;
               w_req_ready_nxt  = 1'b1;
            end
         end

         default: begin
            w_state_nxt      = IDLE;
            w_req_ready_nxt  = 1'b1;
            w_resp_valid_nxt = 1'b0;
            w_mem_ewr_nxt    = 1'b0;
         end
      endcase
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;
   assign mem_ewr    = r_mem_ewr;
   assign mem_dir    = r_mem_dir;
   assign mem_din    = r_mem_din;

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_initiator
// Brief    : Self-checking bench: two initiators (MEM_LAT 1 and 3) on behavioural
//            RAMs, compared each cycle against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_initiator;

   localparam int N     = 2;
   localparam int DEPTH = 256;
   localparam int LAT0  = 1;
   localparam int LAT1  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid  [N];
   logic        req_we     [N];
   logic [31:0] req_addr   [N];
   logic [31:0] req_wdata  [N];
   logic        req_ready  [N];
   logic        resp_valid [N];
   logic        resp_ready [N];
   logic [31:0] resp_rdata [N];
   logic        resp_err   [N];
   logic        mem_ewr    [N];
   logic [31:0] mem_dir    [N];
   logic [31:0] mem_din    [N];
   logic [31:0] mem_dout   [N];

   logic [31:0] ram [N][DEPTH];
   logic        ram_init_done = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_initiator #(.MEM_LAT(LAT0), .DEPTH(DEPTH)) u_dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_we(req_we[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
      .mem_ewr(mem_ewr[0]), .mem_dir(mem_dir[0]), .mem_din(mem_din[0]),
      .mem_dout(mem_dout[0])
   );

   mem_initiator #(.MEM_LAT(LAT1), .DEPTH(DEPTH)) u_dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_we(req_we[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
      .mem_ewr(mem_ewr[1]), .mem_dir(mem_dir[1]), .mem_din(mem_din[1]),
      .mem_dout(mem_dout[1])
   );

   function automatic logic [31:0] init_word(input int d, input int i);
      return (32'(i + 1) * 32'h9E37_79B9) ^ {4'(d), 28'h0};
   endfunction

   function automatic int lat_of(input int d);
      return (d == 0) ? LAT0 : LAT1;
   endfunction

   function automatic logic misaligned(input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
      return (a[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   // Behavioural RAM: asynchronous read, write on the clock edge.
   always @(posedge clk) begin
      if (!ram_init_done) begin
         for (int d = 0; d < N; d++)
            for (int i = 0; i < DEPTH; i++)
               ram[d][i] <= init_word(d, i);
         ram_init_done <= 1'b1;
      end else begin
         for (int d = 0; d < N; d++)
            if (mem_ewr[d] && (mem_dir[d] < 32'(DEPTH)))
               ram[d][mem_dir[d][7:0]] <= mem_din[d];
      end
   end

   always_comb begin
      for (int d = 0; d < N; d++)
         mem_dout[d] = (mem_dir[d] < 32'(DEPTH)) ? ram[d][mem_dir[d][7:0]] : 32'h0;
   end

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model + compare process ----
   logic        m_busy    [N];
   logic        m_chk_rst [N];
   logic        m_we      [N];
   logic        m_err     [N];
   int          m_cyc     [N];
   int          m_lat     [N];
   logic [31:0] m_idx     [N];
   logic [31:0] m_wd      [N];
   logic [31:0] m_rd      [N];
   logic [31:0] m_dir     [N];
   logic [31:0] m_din     [N];
   logic [31:0] model_mem [N][DEPTH];
   logic        cmp_was_busy;

   initial begin
      for (int d = 0; d < N; d++) begin
         for (int i = 0; i < DEPTH; i++) model_mem[d][i] = init_word(d, i);
         m_busy[d] = 1'b0; m_chk_rst[d] = 1'b0; m_cyc[d] = 0; m_lat[d] = 1;
         m_we[d] = 1'b0; m_err[d] = 1'b0;
         m_idx[d] = '0; m_wd[d] = '0; m_rd[d] = '0; m_dir[d] = '0; m_din[d] = '0;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < N; d++) begin
            if (m_chk_rst[d]) begin
               chk("rst_req_ready",  d, req_ready[d],  1);
               chk("rst_resp_valid", d, resp_valid[d], 0);
               chk("rst_resp_err",   d, resp_err[d],   0);
               chk("rst_resp_rdata", d, resp_rdata[d], 0);
               chk("rst_mem_ewr",    d, mem_ewr[d],    0);
               chk("rst_mem_dir",    d, mem_dir[d],    0);
               chk("rst_mem_din",    d, mem_din[d],    0);
            end else if (!m_busy[d]) begin
               chk("idle_req_ready",  d, req_ready[d],  1);
               chk("idle_resp_valid", d, resp_valid[d], 0);
               chk("idle_mem_ewr",    d, mem_ewr[d],    0);
               chk("idle_mem_dir",    d, mem_dir[d],    m_dir[d]);
               chk("idle_mem_din",    d, mem_din[d],    m_din[d]);
            end else begin
               m_cyc[d]++;
               chk("busy_req_ready", d, req_ready[d], 0);
               if (m_cyc[d] < m_lat[d]) begin
                  chk("acc_resp_valid", d, resp_valid[d], 0);
                  chk("acc_mem_ewr",    d, mem_ewr[d],    m_we[d]);
                  chk("acc_mem_dir",    d, mem_dir[d],    m_idx[d]);
                  chk("acc_mem_din",    d, mem_din[d],    m_wd[d]);
               end else begin
                  chk("resp_valid",    d, resp_valid[d], 1);
                  chk("resp_rdata",    d, resp_rdata[d], m_rd[d]);
                  chk("resp_err",      d, resp_err[d],   m_err[d]);
                  chk("resp_mem_ewr",  d, mem_ewr[d],    0);
                  chk("resp_mem_dir",  d, mem_dir[d],    m_dir[d]);
                  chk("resp_mem_din",  d, mem_din[d],    m_din[d]);
               end
            end

            cmp_was_busy = m_busy[d];
            if (rst) begin
               m_busy[d] = 1'b0; m_chk_rst[d] = 1'b1;
               m_dir[d] = '0; m_din[d] = '0;
            end else begin
               m_chk_rst[d] = 1'b0;
               if (m_busy[d] && (m_cyc[d] >= m_lat[d]) && resp_ready[d]) m_busy[d] = 1'b0;
               if (!cmp_was_busy && req_valid[d]) begin
                  m_we[d]  = req_we[d];
                  m_idx[d] = req_addr[d] >> 2;
                  m_wd[d]  = req_wdata[d];
                  m_err[d] = (m_idx[d] >= 32'(DEPTH)) || misaligned(req_addr[d]);
                  m_lat[d] = m_err[d] ? 1 : lat_of(d) + 1;
                  m_rd[d]  = (m_err[d] || m_we[d]) ? 32'h0 : model_mem[d][m_idx[d][7:0]];
                  if (!m_err[d]) begin
                     m_dir[d] = m_idx[d];
                     m_din[d] = m_wd[d];
                     if (m_we[d]) model_mem[d][m_idx[d][7:0]] = m_wd[d];
                  end
                  m_busy[d] = 1'b1;
                  m_cyc[d]  = 0;
               end
            end
         end
      end
   end

   // ---------------- stimulus -------------------------------------------------
   task automatic start_req(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wd);
      int k;
      @(posedge clk); #1;
      req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wd;
      k = 0;
      while (k < 20) begin
         @(negedge clk);
         if (req_ready[d] === 1'b1) break;
         k++;
      end
      if (k >= 20) chk("handshake_timeout", d, 0, 1);
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
   endtask

   task automatic send(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input int hold, output int lat, output logic [31:0] rd, output logic err,
                       output logic ewr1, output logic [31:0] dir1);
      start_req(d, we, addr, wd);
      @(negedge clk);
      lat = 1; ewr1 = mem_ewr[d]; dir1 = mem_dir[d];
      while ((resp_valid[d] !== 1'b1) && (lat < 40)) begin
         @(negedge clk);
         lat++;
      end
      if (resp_valid[d] !== 1'b1) chk("resp_timeout", d, 0, 1);
      rd = resp_rdata[d]; err = resp_err[d];
      repeat (hold) @(negedge clk);
      @(posedge clk); #1 resp_ready[d] = 1'b1;
      @(posedge clk); #1 resp_ready[d] = 1'b0;
   endtask

   initial begin
      int          lat, r_d, r_hold;
      logic [31:0] rd, dir1, r_idx, r_addr, r_wd;
      logic        err, ewr1, r_we;
      logic [1:0]  r_lo;

      for (int d = 0; d < N; d++) begin
         req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
         req_wdata[d] = '0; resp_ready[d] = 1'b0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("pin_rst_req_ready",  0, req_ready[0],  1);
      chk("pin_rst_resp_valid", 0, resp_valid[0], 0);

      // Store then load on the single-cycle initiator.
      send(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, lat, rd, err, ewr1, dir1);
      chk("pin_st_ewr",   0, ewr1, 1);
      chk("pin_st_dir",   0, dir1, 4);
      chk("pin_st_lat",   0, lat,  2);
      chk("pin_st_err",   0, err,  0);
      chk("pin_st_rdata", 0, rd,   0);
      send(0, 1'b0, 32'h10, 32'h0, 1, lat, rd, err, ewr1, dir1);
      chk("pin_ld_rdata", 0, rd,   32'hDEAD_BEEF);
      chk("pin_ld_lat",   0, lat,  2);
      chk("pin_ld_ewr",   0, ewr1, 0);
      send(0, 1'b0, 32'h400, 32'h0, 0, lat, rd, err, ewr1, dir1);
      chk("pin_oor_err",   0, err,  1);
      chk("pin_oor_rdata", 0, rd,   0);
      chk("pin_oor_lat",   0, lat,  1);
      chk("pin_oor_ewr",   0, ewr1, 0);
      chk("pin_oor_dir",   0, dir1, 4);

      // Three-cycle initiator with a stalled response.
      send(1, 1'b1, 32'h20, 32'h55AA_1234, 0, lat, rd, err, ewr1, dir1);
      chk("pin_st3_lat", 1, lat, 4);
      send(1, 1'b0, 32'h20, 32'h0, 5, lat, rd, err, ewr1, dir1);
      chk("pin_ld3_rdata", 1, rd,  32'h55AA_1234);
      chk("pin_ld3_lat",   1, lat, 4);

      // Misaligned store.
      send(0, 1'b1, 32'h12, 32'hCAFE_F00D, 0, lat, rd, err, ewr1, dir1);
      send(0, 1'b0, 32'h10, 32'h0, 0, lat, r_wd, r_we, ewr1, dir1);
`ifdef MEM_ALIGN_CHECK_EN
      chk("pin_mis_err",   0, err,  1);
      chk("pin_mis_rdata", 0, r_wd, 32'hDEAD_BEEF);
`else
      chk("pin_mis_err",   0, err,  0);
      chk("pin_mis_rdata", 0, r_wd, 32'hCAFE_F00D);
`endif

      // Reset during the second access cycle of a three-cycle store.
      start_req(1, 1'b1, 32'h40, 32'h0BAD_F00D);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("pin_mid_ewr", 1, mem_ewr[1], 1);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("pin_abort_ewr",       1, mem_ewr[1],    0);
      chk("pin_abort_resp_vld",  1, resp_valid[1], 0);
      chk("pin_abort_req_ready", 1, req_ready[1],  1);

      // Randomized traffic on both initiators.
      for (int t = 0; t < 80; t++) begin
         r_d = int'($urandom_range(0, 1));
         case ($urandom_range(0, 9))
            0:       r_idx = 32'(256 + $urandom_range(0, 4095));
            1:       r_idx = $urandom >> 2;
            default: r_idx = 32'($urandom_range(0, 31));
         endcase
         r_lo   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         r_addr = {r_idx[29:0], r_lo};
         r_we   = 1'($urandom_range(0, 1));
         r_wd   = $urandom;
         r_hold = int'($urandom_range(0, 3));
         send(r_d, r_we, r_addr, r_wd, r_hold, lat, rd, err, ewr1, dir1);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
